// File: rtl/led_mode_ctrl.sv
// Debounced push-button steps an LED through OFF/FULL/HALF/LOW/FLASH with 8-bit PWM.
// Build option LED_MODE_CTRL_LONG_PRESS_EN: a long press forces the mode back to OFF.
module led_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int FLASH_HALF_PERIOD = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  output logic [2:0] mode,
  output logic       mode_chg,
  output logic       led
);
  // state  | meaning
  // IDLE   | no debounced press
  // HELD   | debounced press, release counts as a short press
  // LONG   | press held past the long-press time, release ignored
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FL_W = $clog2(FLASH_HALF_PERIOD + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF_PERIOD - 1);
  localparam logic [2:0] M_OFF = 3'd0, M_FULL = 3'd1, M_HALF = 3'd2, M_LOW = 3'd3, M_FLASH = 3'd4;

  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1 || FLASH_HALF_PERIOD < 1) begin : g_param_check
    $error("led_mode_ctrl: cycle-count parameters must be at least 1");
  end

  logic            sync1_q, sync2_q, btn_db_q;
  logic [DB_W-1:0] db_cnt_q;
  state_t          state_q;
  logic            adv_q;
  logic            force_off;
  logic [2:0]      mode_q, mode_d;
  logic            mode_chg_q, led_q;
  logic [7:0]      pwm_cnt_q, duty;
  logic [FL_W-1:0] fl_cnt_q;
  logic            fl_off_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      if (sync2_q == btn_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        btn_db_q <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

`ifdef LED_MODE_CTRL_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              long_q;

  // Hold counter stops at HOLD_LAST once LONG is reached, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      adv_q      <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      adv_q  <= 1'b0;
      long_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          hold_cnt_q <= '0;
          if (btn_db_q) state_q <= S_HELD;
        end
        S_HELD: begin
          if (!btn_db_q) begin
            state_q <= S_IDLE;
            adv_q   <= 1'b1;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q <= S_LONG;
            long_q  <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        S_LONG: if (!btn_db_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign force_off = long_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      adv_q   <= 1'b0;
    end else begin
      adv_q <= 1'b0;
      case (state_q)
        S_IDLE: if (btn_db_q) state_q <= S_HELD;
        S_HELD: begin
          if (!btn_db_q) begin
            state_q <= S_IDLE;
            adv_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign force_off = 1'b0;
`endif

  always_comb begin
    mode_d = mode_q;
    if (mode_q > M_FLASH)    mode_d = M_OFF;
    else if (force_off)      mode_d = M_OFF;
    else if (adv_q)          mode_d = (mode_q == M_FLASH) ? M_OFF : mode_q + 3'd1;
  end

  always_comb begin
    duty = 8'd0;
    case (mode_q)
      M_FULL:  duty = 8'd255;
      M_HALF:  duty = 8'd128;
      M_LOW:   duty = 8'd32;
      M_FLASH: duty = fl_off_q ? 8'd0 : 8'd255;
      default: duty = 8'd0;
    endcase
  end

  // Flash timer is held at count 0 / on-phase outside FLASH so every entry starts lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= M_OFF;
      mode_chg_q <= 1'b0;
      pwm_cnt_q  <= 8'd0;
      led_q      <= 1'b0;
      fl_cnt_q   <= '0;
      fl_off_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      mode_chg_q <= (mode_d != mode_q);
      pwm_cnt_q  <= (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
      led_q      <= (pwm_cnt_q < duty);
      if (mode_q != M_FLASH) begin
        fl_cnt_q <= '0;
        fl_off_q <= 1'b0;
      end else if (fl_cnt_q == FL_LAST) begin
        fl_cnt_q <= '0;
        fl_off_q <= ~fl_off_q;
      end else begin
        fl_cnt_q <= fl_cnt_q + 1'b1;
      end
    end
  end

  assign mode     = mode_q;
  assign mode_chg = mode_chg_q;
  assign led      = led_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl: bounce rejection, mode stepping, PWM duty, flash, reset.
module tb_led_mode_ctrl;
  localparam int DB = 4;
  localparam int LP = 20;
  localparam int FH = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] mode;
  logic       mode_chg;
  logic       led;

  int vectors     = 0;
  int miscompares = 0;
  int chg_cnt     = 0;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS_CYCLES(LP),
    .FLASH_HALF_PERIOD(FH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .mode(mode),
    .mode_chg(mode_chg),
    .led(led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_chg === 1'b1) chg_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    button = 1'b1;
    cyc(hi);
    button = 1'b0;
    cyc(lo);
  endtask

  task automatic led_count(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (led === 1'b1) c++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int base;
    bit found;

    rst = 1'b1;
    button = 1'b0;
    cyc(3);
    check("reset_mode", 32'(mode), 0);
    check("reset_chg", 32'(mode_chg), 0);
    check("reset_led", 32'(led), 0);
    rst = 1'b0;
    cyc(2);

    // glitches of 1..3 cycles high, then low, plus a fast chatter burst
    for (int len = 1; len <= 3; len++) begin
      button = 1'b1; cyc(len);
      button = 1'b0; cyc(len);
      button = 1'b1; cyc(1);
      button = 1'b0; cyc(6);
    end
    for (int i = 0; i < 12; i++) begin
      button = i[0]; cyc(1);
    end
    button = 1'b0;
    cyc(8);
    check("bounce_mode", 32'(mode), 0);
    check("bounce_chg", 32'(chg_cnt), 0);

    for (int i = 0; i < 5; i++) begin
      press(10, 10);
      check($sformatf("step_%0d", i), 32'(mode), 32'((i + 1) % 5));
    end
    check("five_chg", 32'(chg_cnt), 5);

    press(10, 12);
    check("full_mode", 32'(mode), 1);
    led_count(510, cnt);
    check("full_duty", 32'(cnt), 510);

    press(10, 12);
    check("half_mode", 32'(mode), 2);
    led_count(510, cnt);
    check("half_duty", 32'(cnt), 256);

    press(10, 12);
    check("low_mode", 32'(mode), 3);
    led_count(510, cnt);
    check("low_duty", 32'(cnt), 64);

    button = 1'b1; cyc(10);
    button = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (mode_chg === 1'b1) found = 1'b1;
    end
    check("flash_entry_seen", 32'(found), 1);
    check("flash_mode", 32'(mode), 4);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check($sformatf("flash_led_%0d", k), 32'(led), 32'((((k - 1) / 10) % 2) == 0));
    end

    press(10, 12);
    check("off_mode", 32'(mode), 0);
    led_count(510, cnt);
    check("off_duty", 32'(cnt), 0);
    check("duty_chg", 32'(chg_cnt), 10);

`ifdef LED_MODE_CTRL_LONG_PRESS_EN
    press(10, 12);
    press(10, 12);
    check("pre_long_mode", 32'(mode), 2);
    button = 1'b1;
    cyc(30);
    check("long_forces_off", 32'(mode), 0);
    button = 1'b0;
    cyc(15);
    check("long_release_mode", 32'(mode), 0);
    check("long_chg", 32'(chg_cnt), 13);
    press(10, 12);
    check("post_long_short", 32'(mode), 1);
    base = 14;
`else
    button = 1'b1;
    cyc(30);
    check("long_hold_mode", 32'(mode), 0);
    button = 1'b0;
    cyc(15);
    check("long_release_adv", 32'(mode), 1);
    base = 11;
`endif
    check("pre_rst_chg", 32'(chg_cnt), 32'(base));

    // reset in the middle of a debounced press
    button = 1'b1;
    cyc(10);
    rst = 1'b1;
    cyc(1);
    check("midrst_mode", 32'(mode), 0);
    check("midrst_chg", 32'(mode_chg), 0);
    check("midrst_led", 32'(led), 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    button = 1'b0;
    cyc(20);
    check("midrst_no_adv", 32'(mode), 0);
    check("midrst_chg_cnt", 32'(chg_cnt), 32'(base));

    // button held through reset: needs a fresh debounce and release to advance
    button = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("held_rst_mode", 32'(mode), 0);
    cyc(7);
    button = 1'b0;
    cyc(15);
    check("held_rst_adv", 32'(mode), 1);
    check("held_rst_chg", 32'(chg_cnt), 32'(base + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: number of consecutive stable synchronized samples before the debounced level changes.
REQ-002 Parameter LONG_PRESS_CYCLES, default 25000000: hold time, in cycles of debounced-high, that qualifies as a long press.
REQ-003 Parameter FLASH_HALF_PERIOD, default 12500000: cycles per on or off phase in FLASH mode.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port button, input, 1: raw asynchronous push-button, active-high (pressed = 1).
REQ-007 Port mode, output, 3: current mode: 0 OFF, 1 FULL, 2 HALF, 3 LOW, 4 FLASH.
REQ-008 Port mode_chg, output, 1: one-cycle pulse on every cycle in which mode changes value.
REQ-009 Port led, output, 1: registered PWM drive to the LED.

Function
REQ-010 button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debounce: btn_db SHALL take the synchronized value only after DEBOUNCE_CYCLES consecutive identical samples differing from btn_db; any mismatch SHALL restart the count from 0.
REQ-012 Press FSM states: IDLE, HELD, LONG; IDLE->HELD on btn_db rising; HELD->IDLE on btn_db falling; HELD->LONG when hold counter reaches LONG_PRESS_CYCLES-1; LONG->IDLE on btn_db falling.
REQ-013 Short press: on HELD->IDLE, mode SHALL advance by one on the following cycle: 0->1->2->3->4->0 (4 wraps to 0).
REQ-014 LONG->IDLE SHALL NOT change mode.
REQ-015 mode values 5..7 SHALL never occur; if detected, mode SHALL go to 0 on the next cycle with mode_chg asserted.
REQ-016 Duty per mode (8-bit): OFF 0, FULL 255, HALF 128, LOW 32, FLASH alternating 255 and 0.
REQ-017 PWM counter SHALL be 8 bits, counting 0..254 and wrapping to 0 (period 255 cycles); led SHALL be registered as (pwm_cnt < duty), so duty 255 means continuously on and duty 0 means continuously off.
REQ-018 Flash timer SHALL run only in FLASH mode, toggle its phase every FLASH_HALF_PERIOD cycles, and start in the on phase with count 0 on every entry to FLASH.
REQ-019 The PWM counter SHALL free-run regardless of mode changes; a new duty SHALL affect led on the first cycle after mode updates.
REQ-020 The hold counter SHALL saturate and never wrap during an arbitrarily long hold.

Reset
REQ-021 On rst=1, all of the following SHALL be cleared on the next clk edge: synchronizer, btn_db, debounce counter, FSM (IDLE), hold counter, PWM counter, flash timer and phase, mode (0), mode_chg (0), led (0).
REQ-022 rst asserted mid-press SHALL discard the press; a button still held after reset release SHALL require a full debounce, then a release, before mode advances.
REQ-023 rst has priority over every other event in the same cycle.

Configuration
REQ-024 Macro LED_MODE_CTRL_LONG_PRESS_EN: when defined, HELD->LONG SHALL also force mode to 0 on the following cycle (mode_chg pulses unless mode was already 0).
REQ-025 Without LED_MODE_CTRL_LONG_PRESS_EN: the LONG state and hold counter SHALL be omitted, and every debounced release SHALL advance mode regardless of hold length.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, FLASH_HALF_PERIOD=10)
REQ-026 Bounce: 1/0 glitches shorter than 4 cycles on button -> mode stays 0 and mode_chg never asserts.
REQ-027 Five clean short presses (high 10 cycles, low 10 cycles) -> mode steps 1,2,3,4,0; exactly five mode_chg pulses.
REQ-028 Duty check, 510 cycles per mode: HALF -> led high 256 cycles; LOW -> 64; FULL -> 510; OFF -> 0.
REQ-029 FLASH with macro undefined -> led alternates 10 cycles high and 10 cycles low, starting high on the cycle after mode becomes 4.
REQ-030 Macro defined, mode 2, hold 30 cycles -> mode becomes 0 about 20 cycles after btn_db rises; release leaves mode at 0; rst mid-hold -> all outputs 0, no advance on release.
